// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc_pkg
// Purpose : Shared definitions for the multi-cycle ALU: op-code values, FSM
//           state encoding and helpers for counter sizing / op classification.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_NOR   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_MULU  = 4'd8;
  localparam logic [3:0] ALU_MULHU = 4'd9;
  localparam logic [3:0] ALU_DIVU  = 4'd10;
  localparam logic [3:0] ALU_REMU  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // mul/div ops run through the shared iterative unit.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MULU) || (op == ALU_MULHU) ||
           (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc_if
// Purpose : Request/response bundle of the multi-cycle ALU.
//           Request : in_valid, in_ready, alu_op, rs, rt
//           Response: out_valid, out_ready, alu_result, zero, overflow, busy
//           master = issuing stage, slave = ALU.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, alu_op, rs, rt, out_ready,
    input  in_ready, out_valid, alu_result, zero, overflow, busy
  );

  modport slave (
    input  in_valid, alu_op, rs, rt, out_ready,
    output in_ready, out_valid, alu_result, zero, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_mc_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc_muldiv_iter
// Purpose : Radix-2 shift-add multiplier / restoring unsigned divider sharing
//           one hi/lo shift register. One iteration per cycle, WIDTH cycles.
// Ports   : clk, rst_n          clock, async active-low reset
//           start, is_div, a, b load operands (a multiplier/dividend)
//           done                final iteration happens on this cycle's edge
//           hi_nxt, lo_nxt      next hi/lo; on done: product {hi,lo} or
//                               remainder (hi) / quotient (lo)
// Revision: 1.0 - initial release
// ============================================================================
module alu_mc_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic             is_div,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  done,
  output logic [WIDTH-1:0]      hi_nxt,
  output logic [WIDTH-1:0]      lo_nxt
);
  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;

  always_comb begin
    w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    // Partial remainder is always < divisor, so the MSB of w_sub is a clean
    // borrow flag. With b==0 it never borrows: quotient all ones, rem = a.
    w_sub   = w_shift - {1'b0, r_b};
    if (r_div) begin
      if (!w_sub[WIDTH]) begin
        hi_nxt = w_sub[WIDTH-1:0];
        lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = w_shift[WIDTH-1:0];
        lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = w_add[WIDTH:1];
      lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  assign done = r_run && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
      r_div <= is_div;
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
    end else if (r_run) begin
      r_hi <= hi_nxt;
      r_lo <= lo_nxt;
      if (done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc
// Purpose : Multi-cycle EX-stage ALU with valid/ready handshake. Logic/add/
//           sub/compare complete in one cycle; mul/div iterate WIDTH cycles.
// Ports   : clk, rst_n   clock, async active-low reset
//           bus (slave)  in_valid/in_ready/alu_op/rs/rt request side,
//                        out_valid/out_ready/alu_result/zero/overflow/busy
// Revision: 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input wire logic clk,
  input wire logic rst_n,
  alu_mc_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;

  logic [3:0]       w_op;
  logic             w_iter;
  logic             w_accept;
  logic             w_handoff;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_fast;
  logic             w_fast_ovf;
  logic [WIDTH-1:0] w_md;
  logic             w_md_done;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign w_op      = 4'(bus.alu_op);
  assign w_iter    = is_iter_op(w_op);
  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_handoff = bus.out_valid && bus.out_ready;

  assign bus.in_ready   = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.busy       = (r_state == ITER);
  assign bus.alu_result = r_result;
  assign bus.zero       = r_zero;
  assign bus.overflow   = r_ovf;

  // Single-cycle datapath; illegal codes fall to result 0 / overflow 0.
  always_comb begin
    w_sum      = bus.rs + bus.rt;
    w_diff     = bus.rs - bus.rt;
    w_fast     = '0;
    w_fast_ovf = 1'b0;
    case (w_op)
      ALU_AND: w_fast = bus.rs & bus.rt;
      ALU_OR:  w_fast = bus.rs | bus.rt;
      ALU_ADD: begin
        w_fast     = w_sum;
        w_fast_ovf = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.rs[WIDTH-1]);
      end
      ALU_SUB: begin
        w_fast     = w_diff;
        w_fast_ovf = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != bus.rs[WIDTH-1]);
      end
      ALU_NOR:  w_fast = ~(bus.rs | bus.rt);
      ALU_XOR:  w_fast = bus.rs ^ bus.rt;
      ALU_SLT:  w_fast = {{(WIDTH-1){1'b0}}, ($signed(bus.rs) < $signed(bus.rt))};
      ALU_SLTU: w_fast = {{(WIDTH-1){1'b0}}, (bus.rs < bus.rt)};
      default:  w_fast = '0;
    endcase
  end

  alu_mc_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept && w_iter),
    .is_div ((w_op == ALU_DIVU) || (w_op == ALU_REMU)),
    .a      (bus.rs),
    .b      (bus.rt),
    .done   (w_md_done),
    .hi_nxt (w_hi_nxt),
    .lo_nxt (w_lo_nxt)
  );

  // Result of the last iteration is taken straight from the unit's next
  // values so DONE follows the final ITER cycle without an extra stage.
  always_comb begin
    case (r_op)
      ALU_MULHU, ALU_REMU: w_md = w_hi_nxt;
      default:             w_md = w_lo_nxt;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_iter ? ITER : DONE;
      ITER: if (w_md_done) w_state_nxt = DONE;
      DONE: begin
        if (w_accept)       w_state_nxt = w_iter ? ITER : DONE;
        else if (w_handoff) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_op <= w_op;
      if (w_accept && !w_iter) begin
        r_result <= w_fast;
        r_zero   <= (w_fast == '0);
        r_ovf    <= w_fast_ovf;
      end else if ((r_state == ITER) && w_md_done) begin
        r_result <= w_md;
        r_zero   <= (w_md == '0);
        r_ovf    <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_mc
// Purpose : Self-checking bench for alu_mc (WIDTH=32) against a behavioural
//           model built from plain integer arithmetic.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_mc;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_mc_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_mc #(.WIDTH(32), .OPW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic o);
    longint sa, sb, s;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = 64'(a) * 64'(b);
    o  = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a + b; s = sa + sb; o = (s != longint'($signed(r))); end
      4'd3: begin r = a - b; s = sa - sb; o = (s != longint'($signed(r))); end
      4'd4: r = ~(a | b);
      4'd5: r = a ^ b;
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: r = p[31:0];
      4'd9: r = p[63:32];
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
  endtask

  // Called half-way into a cycle with the DUT ready; returns aligned the same way.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er;
    logic        eo;
    logic        long_op;
    int          k;
    int          nb;
    model(op, a, b, er, eo);
    long_op = (op >= 4'd8) && (op <= 4'd11);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.rs       = a;
    bus.rt       = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'($urandom);
    bus.rs       = $urandom;
    bus.rt       = $urandom;
    k  = 0;
    nb = 0;
    while (!bus.out_valid && k < 100) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".lat"}, 64'(k), long_op ? 64'd32 : 64'd0);
    check({tag, ".busy"}, 64'(nb), long_op ? 64'd32 : 64'd0);
    check({tag, ".res"}, 64'(bus.alu_result), 64'(er));
    check({tag, ".zero"}, 64'(bus.zero), 64'(er == 32'd0));
    check({tag, ".ovf"}, 64'(bus.overflow), 64'(eo));
    @(posedge clk); #1;
    check({tag, ".handoff"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic        eo;
    int          nv;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op   = 4'd0;
    bus.rs       = 32'd0;
    bus.rt       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.res", 64'(bus.alu_result), 64'd0);
    check("rst.zero", 64'(bus.zero), 64'd1);
    check("rst.ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    run_op(4'd3, 32'd5, 32'd5, "sub_zero");
    run_op(4'd3, 32'h8000_0000, 32'd1, "sub_ovf");
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu");
    run_op(4'd10, 32'd7, 32'd0, "divu0");
    run_op(4'd11, 32'd7, 32'd0, "remu0");
    run_op(4'd10, 32'd100, 32'd7, "divu");
    run_op(4'd11, 32'd100, 32'd7, "remu");
    run_op(4'd13, 32'd9, 32'd4, "illegal");

    // Consumer stall, then handoff and new accept on the same edge.
    model(4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234, er, eo);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'd5;
    bus.rs        = 32'hA5A5_0F0F;
    bus.rt        = 32'h0FF0_1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs       = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", 64'(bus.out_valid), 64'd1);
      check("stall.res", 64'(bus.alu_result), 64'(er));
      check("stall.in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    model(4'd0, 32'hF0F0_FFFF, 32'h3333_0000, er, eo);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'd0;
    bus.rs        = 32'hF0F0_FFFF;
    bus.rt        = 32'h3333_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b.valid", 64'(bus.out_valid), 64'd1);
    check("b2b.res", 64'(bus.alu_result), 64'(er));
    @(posedge clk); #1;
    check("b2b.handoff", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a divide.
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'd10;
    bus.rs       = 32'd1000;
    bus.rt       = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid.busy", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst.busy", 64'(bus.busy), 64'd0);
    check("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst.in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst.res", 64'(bus.alu_result), 64'd0);
    check("mrst.zero", 64'(bus.zero), 64'd1);
    check("mrst.ovf", 64'(bus.overflow), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) nv++;
    end
    check("mrst.no_result", 64'(nv), 64'd0);
    run_op(4'd2, 32'd2, 32'd3, "add_after_rst");

    // Randomised ops across the whole code space.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 7));
        1:       b = a;
        default: b = $urandom;
      endcase
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
